// File: rtl/up_sample_stream_if.sv
// Handshake bundle for up_sample_stream: input sample stream in, 2x upsampled stream out.
interface up_sample_stream_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  frame_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, frame_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, frame_done
  );
endinterface

// File: rtl/up_sample_stream.sv
// 2x stream upsampler: each accepted sample is emitted twice (MODE=0) or followed
// by a zero (MODE=1); out_last marks the second copy of sample InputW-1 of a frame.
module up_sample_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int InputW     = 128,
  parameter int MODE       = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  up_sample_stream_if.slave  bus
);

  localparam int CntW = (InputW > 1) ? $clog2(InputW) : 1;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] PH0   = 2'd1;
  localparam logic [1:0] PH1   = 2'd2;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] sample;
  logic [CntW-1:0]       sampleCnt;
  logic                  isLast;
  logic                  frameDone;
  logic                  rstDone;

  logic                  inReady;
  logic                  outValid;
  logic [DATA_WIDTH-1:0] outData;
  logic                  outLast;
  logic                  inXfer;
  logic                  outXfer;

  // rstDone keeps in_ready low until the first edge after reset release
  always_comb begin
    inReady  = 1'b0;
    outValid = 1'b0;
    outData  = sample;
    outLast  = 1'b0;
    case (state)
      EMPTY: inReady = rstDone;
      PH0:   outValid = 1'b1;
      PH1: begin
        outValid = 1'b1;
        inReady  = rstDone & bus.out_ready;
        outLast  = isLast;
        if (MODE == 1) outData = '0;
      end
      default: ;
    endcase
    inXfer  = bus.in_valid & inReady;
    outXfer = outValid & bus.out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      sample    <= '0;
      sampleCnt <= '0;
      isLast    <= 1'b0;
      frameDone <= 1'b0;
      rstDone   <= 1'b0;
    end else begin
      rstDone   <= 1'b1;
      frameDone <= outXfer & outLast;

      if (inXfer) begin
        sample    <= bus.in_data;
        isLast    <= (sampleCnt == CntW'(InputW - 1));
        sampleCnt <= (sampleCnt == CntW'(InputW - 1)) ? '0 : sampleCnt + 1'b1;
      end

      case (state)
        EMPTY:   if (inXfer) state <= PH0;
        PH0:     if (outXfer) state <= PH1;
        PH1:     if (outXfer) state <= inXfer ? PH0 : EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.in_ready   = inReady;
  assign bus.out_valid  = outValid;
  assign bus.out_data   = outData;
  assign bus.out_last   = outLast;
  assign bus.frame_done = frameDone;

endmodule

// File: tb/tb_up_sample_stream.sv
// Bench for up_sample_stream: MODE=0 and MODE=1 instances share stimulus and are
// checked against a queue model of the expected output stream.
module tb_up_sample_stream;

  localparam int DW = 16;
  localparam int IW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          inValid;
  logic          outReady;
  logic [DW-1:0] inData;

  up_sample_stream_if #(.DATA_WIDTH(DW)) bus0 ();
  up_sample_stream_if #(.DATA_WIDTH(DW)) bus1 ();

  assign bus0.in_valid  = inValid;
  assign bus0.in_data   = inData;
  assign bus0.out_ready = outReady;
  assign bus1.in_valid  = inValid;
  assign bus1.in_data   = inData;
  assign bus1.out_ready = outReady;

  up_sample_stream #(.DATA_WIDTH(DW), .InputW(IW), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  up_sample_stream #(.DATA_WIDTH(DW), .InputW(IW), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  typedef struct packed {
    logic          copy;
    logic          last;
    logic [DW-1:0] smp;
  } item_t;

  item_t       expQ[$];
  int unsigned inPos;
  logic        expFd;
  int          vecs;
  int          errs;
  int unsigned accepted;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sampleOuts(output logic ov[2], output logic ir[2], output logic [DW-1:0] od[2],
                            output logic ol[2], output logic fd[2]);
    ov[0] = bus0.out_valid;  ov[1] = bus1.out_valid;
    ir[0] = bus0.in_ready;   ir[1] = bus1.in_ready;
    od[0] = bus0.out_data;   od[1] = bus1.out_data;
    ol[0] = bus0.out_last;   ol[1] = bus1.out_last;
    fd[0] = bus0.frame_done; fd[1] = bus1.frame_done;
  endtask

  // One clock cycle: drive after the falling edge, check, then advance the model
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, output logic took);
    logic          ov[2], ir[2], ol[2], fd[2];
    logic [DW-1:0] od[2];
    logic [DW-1:0] expData;
    logic          expIr, outX, inX, lastIn;
    item_t         head;
    @(negedge clk);
    inValid  = v;
    inData   = d;
    outReady = r;
    #1;
    sampleOuts(ov, ir, od, ol, fd);
    head  = (expQ.size() != 0) ? expQ[0] : '0;
    expIr = (expQ.size() == 0) || (expQ.size() == 1 && r);
    for (int m = 0; m < 2; m++) begin
      checkVal($sformatf("m%0d out_valid", m), 32'(ov[m]), 32'(expQ.size() != 0));
      checkVal($sformatf("m%0d in_ready", m), 32'(ir[m]), 32'(expIr));
      checkVal($sformatf("m%0d frame_done", m), 32'(fd[m]), 32'(expFd));
      if (expQ.size() != 0) begin
        expData = (m == 1 && head.copy) ? '0 : head.smp;
        checkVal($sformatf("m%0d out_data", m), 32'(od[m]), 32'(expData));
        checkVal($sformatf("m%0d out_last", m), 32'(ol[m]), 32'(head.last));
      end
    end
    outX  = (expQ.size() != 0) && r;
    inX   = v && expIr;
    expFd = outX && head.last;
    if (outX) void'(expQ.pop_front());
    if (inX) begin
      lastIn = (inPos == IW - 1);
      expQ.push_back('{copy: 1'b0, last: 1'b0,   smp: d});
      expQ.push_back('{copy: 1'b1, last: lastIn, smp: d});
      inPos = (inPos + 1) % IW;
      accepted++;
    end
    took = inX;
  endtask

  task automatic feed(input logic [DW-1:0] d);
    logic took = 1'b0;
    for (int i = 0; i < 10 && !took; i++) step(1'b1, d, 1'b1, took);
    if (!took) checkVal("feed timeout", 32'(took), 32'd1);
  endtask

  task automatic drain();
    logic took;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) step(1'b0, DW'($urandom), 1'b1, took);
    step(1'b0, DW'($urandom), 1'b1, took);
  endtask

  task automatic doReset();
    logic          ov[2], ir[2], ol[2], fd[2];
    logic [DW-1:0] od[2];
    @(negedge clk);
    rst_n   = 1'b0;
    inValid = 1'b1;
    inData  = DW'($urandom);
    #1;
    sampleOuts(ov, ir, od, ol, fd);
    for (int m = 0; m < 2; m++) begin
      checkVal($sformatf("m%0d rst out_valid", m), 32'(ov[m]), 32'd0);
      checkVal($sformatf("m%0d rst in_ready", m), 32'(ir[m]), 32'd0);
      checkVal($sformatf("m%0d rst out_data", m), 32'(od[m]), 32'd0);
      checkVal($sformatf("m%0d rst out_last", m), 32'(ol[m]), 32'd0);
      checkVal($sformatf("m%0d rst frame_done", m), 32'(fd[m]), 32'd0);
    end
    repeat (2) @(negedge clk);
    expQ.delete();
    inPos = 0;
    expFd = 1'b0;
    inValid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] seqA[4];
    logic          took;
    int unsigned   base;
    vecs = 0; errs = 0; accepted = 0; inPos = 0; expFd = 1'b0;
    inValid = 1'b0; outReady = 1'b0; inData = '0;
    seqA[0] = DW'(3); seqA[1] = DW'(-5); seqA[2] = DW'(7); seqA[3] = DW'(9);

    doReset();

    // one frame, then two frames back to back
    for (int i = 0; i < 4; i++) feed(seqA[i]);
    drain();
    for (int i = 0; i < 8; i++) feed(DW'($urandom));
    drain();

    // output stall while the first copy is pending
    feed(16'h7FFF);
    for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0, took);
    drain();

    // reset mid-frame, then a full fresh frame
    feed(DW'(11));
    feed(DW'(22));
    doReset();
    for (int i = 0; i < 4; i++) feed(DW'($urandom));
    drain();

    // random handshakes
    base = accepted;
    for (int c = 0; c < 20000 && (accepted - base) < 1000; c++)
      step(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 3) != 0), took);
    if ((accepted - base) < 1000) checkVal("random timeout", accepted - base, 32'd1000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/up_sample_stream.md
UP_SAMPLE_STREAM -- requirements
Module: up_sample_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 16, is the width of one fixed-point sample in bits.
REQ-002 Parameter InputW, default 128, is the number of input samples per frame; each frame produces 2*InputW output samples.
REQ-003 Parameter MODE, default 0, selects the fill rule: 0 = nearest-neighbour repeat, 1 = zero insertion.
REQ-004 Port clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit, is the reset; it SHALL be asynchronous and active-low.
REQ-006 Port in_valid, input, 1 bit, SHALL indicate that in_data holds a valid sample.
REQ-007 Port in_ready, output, 1 bit, SHALL indicate that the block accepts a sample this cycle.
REQ-008 Port in_data, input, DATA_WIDTH bits, is the signed input sample.
REQ-009 Port out_valid, output, 1 bit, SHALL indicate that out_data holds a valid sample.
REQ-010 Port out_ready, input, 1 bit, SHALL indicate that the downstream consumer accepts out_data this cycle.
REQ-011 Port out_data, output, DATA_WIDTH bits, is the signed output sample.
REQ-012 Port out_last, output, 1 bit, SHALL mark the final output sample of a frame.
REQ-013 Port frame_done, output, 1 bit, SHALL pulse for one cycle after the last output sample of a frame transfers.

Function
REQ-014 An input transfer SHALL occur when in_valid and in_ready are both high on a clock edge, and an output transfer SHALL occur when out_valid and out_ready are both high on a clock edge.
REQ-015 The block SHALL hold a one-sample register and a three-state FSM: EMPTY, PH0 (first copy pending) and PH1 (second copy pending).
REQ-016 In EMPTY, in_ready SHALL be 1 and out_valid 0; an input transfer SHALL capture in_data and move the FSM to PH0.
REQ-017 In PH0, out_valid SHALL be 1 and out_data SHALL equal the held sample; an output transfer SHALL move the FSM to PH1.
REQ-018 In PH1, out_valid SHALL be 1 and out_data SHALL equal the held sample when MODE=0, or 0 when MODE=1.
REQ-019 In PH1, in_ready SHALL equal out_ready, so that a same-cycle input and output transfer loads the new sample and returns the FSM to PH0.
REQ-020 In PH1, an output transfer without an input transfer SHALL return the FSM to EMPTY.
REQ-021 in_ready SHALL be 0 in PH0, and in PH1 whenever out_ready is 0.
REQ-022 Latency SHALL be one cycle from an input transfer to out_valid; sustained throughput SHALL be one output per cycle and one input per two cycles.
REQ-023 The data path SHALL be a plain copy with no arithmetic, sign extension or rounding; zero fill SHALL be all bits 0.
REQ-024 An input sample counter of width $clog2(InputW), minimum 1, SHALL increment on each input transfer and wrap from InputW-1 to 0.
REQ-025 The block SHALL record whether the held sample is sample InputW-1 of its frame.
REQ-026 out_last SHALL be 1 only in PH1 while the held sample is the last sample of the frame.
REQ-027 frame_done SHALL be registered and SHALL be 1 in the cycle after an output transfer that has out_last=1.
REQ-028 While out_valid=1 and out_ready=0, out_data, out_last and the FSM state SHALL remain stable.
REQ-029 in_data SHALL be ignored whenever no input transfer occurs.
REQ-030 A frame boundary SHALL need no idle cycle: sample 0 of the next frame may be accepted in the same cycle as the out_last transfer.

Reset
REQ-031 While rst_n=0, the FSM SHALL be EMPTY, and the sample register, counter, last flag, out_valid, out_data, out_last and frame_done SHALL all be 0.
REQ-032 While rst_n=0, in_ready SHALL be 0; it SHALL become 1 on the first clock edge after rst_n deasserts.
REQ-033 Reset asserted mid-frame SHALL discard the held sample and the partial frame; after release, the next accepted sample SHALL be sample 0.

Verification
REQ-034 Scenario: MODE=0, InputW=4, out_ready=1, inputs 3,-5,7,9 presented back-to-back -> out_data 3,3,-5,-5,7,7,9,9 on consecutive cycles, out_last on the final 9, frame_done one cycle later.
REQ-035 Scenario: MODE=1, same stimulus -> out_data 3,0,-5,0,7,0,9,0, with out_last on the final 0.
REQ-036 Scenario: out_ready held 0 for 5 cycles while in PH0 holding 0x7FFF -> out_data stays 0x7FFF, in_ready stays 0, then both copies transfer once out_ready returns to 1.
REQ-037 Scenario: two frames streamed with no gap -> the second frame's first output follows the first frame's out_last with no bubble, and the counter wraps to 0.
REQ-038 Scenario: rst_n pulsed low after 2 of 4 inputs -> all outputs are 0 during reset; the next frame produces 8 outputs with out_last on the 8th.
REQ-039 Scenario: random in_valid and out_ready, 1000 samples -> the output sequence equals the per-MODE golden expansion and no sample is lost or duplicated.
